// File: rtl/window_fetcher_pkg.sv
// Shared definitions for the BRAM-to-blur window fetch path: read latency,
// return-path tags and the packed three-pixel row width.
package window_fetcher_pkg;

   localparam int BRAM_RD_LATENCY = 2;

   typedef enum logic [1:0] {
      POS_TOP = 2'd0,
      POS_MID = 2'd1,
      POS_BOT = 2'd2
   } row_pos_e;

   // Travels alongside each BRAM read so the returning word can be placed.
   typedef struct packed {
      row_pos_e pos;
      logic     first_col;
      logic     last_col;
   } win_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;

   function automatic int window_row_w(input int width);
      return 3 * width;
   endfunction

endpackage

// File: rtl/window_fetcher_addr_gen.sv
// Walks the image in column-of-three order (row above, row, row below) and
// registers one clamped BRAM address plus its return tag per issued read.
module window_addr_gen
   import window_fetcher_pkg::*;
#(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              issue_in,
   output logic [ADDR_W-1:0] addr_out,
   output win_tag_t          tag_out,
   output logic              valid_out,
   output logic              last_out
);

   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [1:0]        phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   win_tag_t          tag_q, tag_d;
   logic              valid_q, valid_d;

   logic [ROW_W-1:0]  rd_row;
   logic              at_last_row;
   logic              at_last_col;

   always_comb begin
      at_last_row = (row_q == ROW_W'(IMG_H - 1));
      at_last_col = (col_q == COL_W'(IMG_W - 1));

      // Edge replication: the neighbour row is clamped into the image.
      rd_row = row_q;
      case (phase_q)
         2'd0:    if (row_q != '0) rd_row = row_q - ROW_W'(1);
         2'd2:    if (!at_last_row) rd_row = row_q + ROW_W'(1);
         default: rd_row = row_q;
      endcase

      row_d   = row_q;
      col_d   = col_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      valid_d = 1'b0;

      if (issue_in) begin
         addr_d = ADDR_W'(rd_row) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
         case (phase_q)
            2'd0:    tag_d.pos = POS_TOP;
            2'd1:    tag_d.pos = POS_MID;
            default: tag_d.pos = POS_BOT;
         endcase
         tag_d.first_col = (col_q == '0);
         tag_d.last_col  = at_last_col;
         valid_d         = 1'b1;

         if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            if (at_last_col) begin
               col_d = '0;
               row_d = at_last_row ? '0 : row_q + ROW_W'(1);
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end else begin
            phase_d = phase_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         row_q   <= '0;
         col_q   <= '0;
         phase_q <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         row_q   <= row_d;
         col_q   <= col_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
      end
   end

   assign addr_out  = addr_q;
   assign tag_out   = tag_q;
   assign valid_out = valid_q;
   assign last_out  = at_last_row && at_last_col && (phase_q == 2'd2);

endmodule

// File: rtl/window_fetcher.sv
// Streams one edge-replicated 3x3 window per pixel, in raster order, from a
// 2-cycle-latency BRAM into the blur stage's three-row packed input.
module window_fetcher
   import window_fetcher_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   output logic [ADDR_W-1:0]  addr_out,
   input  logic [WIDTH-1:0]   rd_data_in,
   output logic [3*WIDTH-1:0] r0_data_out,
   output logic [3*WIDTH-1:0] r1_data_out,
   output logic [3*WIDTH-1:0] r2_data_out,
   output logic               data_valid_out,
   output logic               busy_out,
   output logic               done_out
);

   localparam int ROW_BITS = window_row_w(WIDTH);
   localparam int LAT      = BRAM_RD_LATENCY;

   typedef logic [2:0][WIDTH-1:0] col_t;

   fetch_state_e state_q, state_d;
   logic         issue;

   logic [ADDR_W-1:0] gen_addr;
   win_tag_t          gen_tag;
   logic              gen_valid;
   logic              gen_last;

   logic [LAT-1:0]           vdl_q, vdl_d;
   win_tag_t [LAT-1:0]       tdl_q, tdl_d;
   logic                     ret_valid;
   win_tag_t                 ret_tag;

   logic [WIDTH-1:0]    top_q, top_d;
   logic [WIDTH-1:0]    mid_q, mid_d;
   col_t                col_l_q, col_l_d;
   col_t                col_c_q, col_c_d;
   col_t                new_col;
   logic [ROW_BITS-1:0] r0_q, r0_d;
   logic [ROW_BITS-1:0] r1_q, r1_d;
   logic [ROW_BITS-1:0] r2_q, r2_d;
   logic                valid_q, valid_d;
   logic                edge_q, edge_d;

   function automatic logic [ROW_BITS-1:0] pack_row(input logic [WIDTH-1:0] l,
                                                    input logic [WIDTH-1:0] c,
                                                    input logic [WIDTH-1:0] r);
      return {r, c, l};
   endfunction

   window_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .issue_in  (issue),
      .addr_out  (gen_addr),
      .tag_out   (gen_tag),
      .valid_out (gen_valid),
      .last_out  (gen_last)
   );

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               issue   = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            issue = 1'b1;
            if (gen_last) state_d = ST_DRAIN;
         end
         // Wait for the final column and its right-edge window to leave.
         ST_DRAIN: begin
            if (!gen_valid && (vdl_q == '0) && !edge_q) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vdl_d[0] = gen_valid;
      tdl_d[0] = gen_tag;
      for (int i = 1; i < LAT; i++) begin
         vdl_d[i] = vdl_q[i-1];
         tdl_d[i] = tdl_q[i-1];
      end
      ret_valid = vdl_q[LAT-1];
      ret_tag   = tdl_q[LAT-1];
      new_col   = {rd_data_in, mid_q, top_q};

      top_d   = top_q;
      mid_d   = mid_q;
      col_l_d = col_l_q;
      col_c_d = col_c_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      valid_d = 1'b0;
      edge_d  = 1'b0;

      if (ret_valid) begin
         case (ret_tag.pos)
            POS_TOP: top_d = rd_data_in;
            POS_MID: mid_d = rd_data_in;
            POS_BOT: begin
               if (ret_tag.first_col) begin
                  col_l_d = new_col;
                  col_c_d = new_col;
               end else begin
                  r0_d    = pack_row(col_l_q[0], col_c_q[0], new_col[0]);
                  r1_d    = pack_row(col_l_q[1], col_c_q[1], new_col[1]);
                  r2_d    = pack_row(col_l_q[2], col_c_q[2], new_col[2]);
                  valid_d = 1'b1;
                  col_l_d = col_c_q;
                  col_c_d = new_col;
               end
               edge_d = ret_tag.last_col;
            end
            default: ;
         endcase
      end

      // The column register now holds the last column; repeat it as the right.
      if (edge_q) begin
         r0_d    = pack_row(col_l_q[0], col_c_q[0], col_c_q[0]);
         r1_d    = pack_row(col_l_q[1], col_c_q[1], col_c_q[1]);
         r2_d    = pack_row(col_l_q[2], col_c_q[2], col_c_q[2]);
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
         vdl_q   <= '0;
         tdl_q   <= '0;
         top_q   <= '0;
         mid_q   <= '0;
         col_l_q <= '0;
         col_c_q <= '0;
         r0_q    <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         valid_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vdl_q   <= vdl_d;
         tdl_q   <= tdl_d;
         top_q   <= top_d;
         mid_q   <= mid_d;
         col_l_q <= col_l_d;
         col_c_q <= col_c_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         valid_q <= valid_d;
         edge_q  <= edge_d;
      end
   end

   assign addr_out       = gen_addr;
   assign r0_data_out    = r0_q;
   assign r1_data_out    = r1_q;
   assign r2_data_out    = r2_q;
   assign data_valid_out = valid_q;
   assign busy_out       = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done_out       = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_fetcher.sv
// Bench for window_fetcher: a 4x4 instance for the fixed vectors and cycle
// checks, a 5x3 instance for random frames, both against a clamped-window model.
module tb_window_fetcher;

   localparam int WIDTH = 8;
   localparam int RW    = 3 * WIDTH;
   localparam int AW    = 4;
   localparam int AH    = 4;
   localparam int BW    = 5;
   localparam int BH    = 3;
   localparam int A_ADW = $clog2(AW*AH);
   localparam int B_ADW = $clog2(BW*BH);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_a, start_a, valid_a, busy_a, done_a;
   logic [A_ADW-1:0] addr_a;
   logic [WIDTH-1:0] rd_a, pipe_a;
   logic [RW-1:0]    r0_a, r1_a, r2_a;

   logic             rst_b, start_b, valid_b, busy_b, done_b;
   logic [B_ADW-1:0] addr_b;
   logic [WIDTH-1:0] rd_b, pipe_b;
   logic [RW-1:0]    r0_b, r1_b, r2_b;

   window_fetcher #(.WIDTH(WIDTH), .IMG_W(AW), .IMG_H(AH), .ADDR_W(A_ADW)) dut_a (
      .clk_in(clk), .rst_in(rst_a), .start_in(start_a), .addr_out(addr_a),
      .rd_data_in(rd_a), .r0_data_out(r0_a), .r1_data_out(r1_a), .r2_data_out(r2_a),
      .data_valid_out(valid_a), .busy_out(busy_a), .done_out(done_a)
   );

   window_fetcher #(.WIDTH(WIDTH), .IMG_W(BW), .IMG_H(BH), .ADDR_W(B_ADW)) dut_b (
      .clk_in(clk), .rst_in(rst_b), .start_in(start_b), .addr_out(addr_b),
      .rd_data_in(rd_b), .r0_data_out(r0_b), .r1_data_out(r1_b), .r2_data_out(r2_b),
      .data_valid_out(valid_b), .busy_out(busy_b), .done_out(done_b)
   );

   // Two-cycle BRAM models
   logic [WIDTH-1:0] mem_a [AW*AH];
   logic [WIDTH-1:0] mem_b [BW*BH];

   always @(posedge clk) begin
      pipe_a <= mem_a[addr_a];
      rd_a   <= pipe_a;
      pipe_b <= (int'(addr_b) < BW*BH) ? mem_b[addr_b] : '0;
      rd_b   <= pipe_b;
   end

   int            sel;
   logic          obs_valid, obs_busy, obs_done;
   logic [15:0]   obs_addr;
   logic [RW-1:0] obs_r0, obs_r1, obs_r2;

   always_comb begin
      if (sel != 0) begin
         obs_valid = valid_b; obs_busy = busy_b; obs_done = done_b;
         obs_addr  = 16'(addr_b);
         obs_r0 = r0_b; obs_r1 = r1_b; obs_r2 = r2_b;
      end else begin
         obs_valid = valid_a; obs_busy = busy_a; obs_done = done_a;
         obs_addr  = 16'(addr_a);
         obs_r0 = r0_a; obs_r1 = r1_a; obs_r2 = r2_a;
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [3*RW-1:0] exp_q[$];
   int              exp_t[$];
   logic [15:0]     exp_addr[$];
   logic [3*RW-1:0] got_win[$];
   int              got_vt[$];
   int              got_done[$];
   logic [15:0]     got_addr[$];
   int              busy_err;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int img_w(input int s);
      return (s != 0) ? BW : AW;
   endfunction

   function automatic int img_h(input int s);
      return (s != 0) ? BH : AH;
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [WIDTH-1:0] pix(input int s, input int a);
      return (s != 0) ? mem_b[a] : mem_a[a];
   endfunction

   // Window at (x,y) straight from the clamped-neighbourhood definition.
   function automatic logic [3*RW-1:0] model_win(input int s, input int x, input int y);
      logic [RW-1:0] r [3];
      int w, h;
      w = img_w(s);
      h = img_h(s);
      for (int dy = 0; dy < 3; dy++) begin
         r[dy] = '0;
         for (int dx = 0; dx < 3; dx++)
            r[dy][dx*WIDTH +: WIDTH] = pix(s, clampi(y+dy-1, h-1)*w + clampi(x+dx-1, w-1));
      end
      return {r[0], r[1], r[2]};
   endfunction

   task automatic build_exp(input int s);
      int w, h, t;
      w = img_w(s);
      h = img_h(s);
      exp_q.delete(); exp_t.delete(); exp_addr.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            exp_q.push_back(model_win(s, x, y));
      // Column c's third read goes out at cycle 3*(y*w+c)+3; window 3 later.
      for (int y = 0; y < h; y++)
         for (int c = 1; c < w; c++) begin
            t = 3*(y*w + c) + 6;
            exp_t.push_back(t);
            if (c == w-1) exp_t.push_back(t + 1);
         end
      for (int y = 0; y < h; y++)
         for (int c = 0; c < w; c++) begin
            exp_addr.push_back(16'(clampi(y-1, h-1)*w + c));
            exp_addr.push_back(16'(y*w + c));
            exp_addr.push_back(16'(clampi(y+1, h-1)*w + c));
         end
   endtask

   // ---------------- driver ----------------
   // rel counts cycles from the one where start is sampled (rel 0).
   task automatic run_frame(input int s, input int rst_at, input int x1, input int x2, input int x3);
      int n, maxc;
      logic st, rs;
      n    = 3 * img_w(s) * img_h(s);
      maxc = n + 12;
      sel  = s;
      got_win.delete(); got_vt.delete(); got_done.delete(); got_addr.delete();
      busy_err = 0;
      for (int rel = 0; rel <= maxc; rel++) begin
         @(negedge clk);
         if (rel >= 1) begin
            if (obs_valid) begin
               got_win.push_back({obs_r0, obs_r1, obs_r2});
               got_vt.push_back(rel);
            end
            if (obs_done) got_done.push_back(rel);
            if (rel <= n) got_addr.push_back(obs_addr);
            if (rst_at < 0 && obs_busy !== (rel <= n + 4)) busy_err++;
            if (rel == rst_at + 1) begin
               check("reset addr",  96'(obs_addr),  96'(0));
               check("reset r0",    96'(obs_r0),    96'(0));
               check("reset r1",    96'(obs_r1),    96'(0));
               check("reset r2",    96'(obs_r2),    96'(0));
               check("reset valid", 96'(obs_valid), 96'(0));
               check("reset busy",  96'(obs_busy),  96'(0));
               check("reset done",  96'(obs_done),  96'(0));
            end
         end
         st = (rel == 0) || (rel == x1) || (rel == x2) || (rel == x3);
         rs = !(rel == rst_at);
         if (s != 0) begin start_b = st; rst_b = rs; end
         else        begin start_a = st; rst_a = rs; end
      end
   endtask

   task automatic check_frame(input int s, input string tag);
      int n;
      n = 3 * img_w(s) * img_h(s);
      build_exp(s);
      check({tag, " window count"}, 96'(got_win.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_win.size())
            check($sformatf("%s window %0d", tag, i), 96'(got_win[i]), 96'(exp_q[i]));
      for (int i = 0; i < exp_t.size(); i++)
         if (i < got_vt.size())
            check($sformatf("%s valid cycle %0d", tag, i), 96'(got_vt[i]), 96'(exp_t[i]));
      check({tag, " done count"}, 96'(got_done.size()), 96'(1));
      if (got_done.size() > 0)
         check({tag, " done cycle"}, 96'(got_done[0]), 96'(n + 5));
      check({tag, " busy profile errors"}, 96'(busy_err), 96'(0));
      for (int i = 0; i < n; i++)
         check($sformatf("%s addr %0d", tag, i), 96'(got_addr[i]), 96'(exp_addr[i]));
   endtask

   typedef struct {
      int            x;
      int            y;
      logic [RW-1:0] r0;
      logic [RW-1:0] r1;
      logic [RW-1:0] r2;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int pre, idx, n;

      tbl[0] = '{1, 1, {8'd2, 8'd1, 8'd0},    {8'd6, 8'd5, 8'd4},    {8'd10, 8'd9, 8'd8}};
      tbl[1] = '{0, 0, {8'd1, 8'd0, 8'd0},    {8'd1, 8'd0, 8'd0},    {8'd5, 8'd4, 8'd4}};
      tbl[2] = '{3, 3, {8'd11, 8'd11, 8'd10}, {8'd15, 8'd15, 8'd14}, {8'd15, 8'd15, 8'd14}};
      tbl[3] = '{3, 0, {8'd3, 8'd3, 8'd2},    {8'd3, 8'd3, 8'd2},    {8'd7, 8'd7, 8'd6}};

      for (int i = 0; i < AW*AH; i++) mem_a[i] = WIDTH'(i);
      for (int i = 0; i < BW*BH; i++) mem_b[i] = WIDTH'($urandom);
      sel = 0;
      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         check("por addr",  96'(obs_addr),  96'(0));
         check("por r0",    96'(obs_r0),    96'(0));
         check("por r1",    96'(obs_r1),    96'(0));
         check("por r2",    96'(obs_r2),    96'(0));
         check("por valid", 96'(obs_valid), 96'(0));
         check("por busy",  96'(obs_busy),  96'(0));
         check("por done",  96'(obs_done),  96'(0));
      end
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Word = address image: fixed vectors, timing and address order.
      run_frame(0, -1, -1, -1, -1);
      check_frame(0, "addr-image");
      for (int i = 0; i < 4; i++) begin
         idx = tbl[i].y * AW + tbl[i].x;
         if (idx < got_win.size())
            check($sformatf("table window (%0d,%0d)", tbl[i].x, tbl[i].y),
                  96'(got_win[idx]), 96'({tbl[i].r0, tbl[i].r1, tbl[i].r2}));
      end

      // Reset mid-frame at cycle 20, then a clean frame with new data.
      for (int i = 0; i < AW*AH; i++) mem_a[i] = WIDTH'($urandom);
      run_frame(0, 20, -1, -1, -1);
      build_exp(0);
      pre = 0;
      foreach (exp_t[i]) if (exp_t[i] <= 20) pre++;
      check("reset frame window count", 96'(got_win.size()), 96'(pre));
      check("reset frame done count", 96'(got_done.size()), 96'(0));
      for (int i = 0; i < pre; i++)
         if (i < got_win.size())
            check($sformatf("reset frame window %0d", i), 96'(got_win[i]), 96'(exp_q[i]));
      repeat (3) @(negedge clk);
      for (int i = 0; i < AW*AH; i++) mem_a[i] = WIDTH'($urandom);
      run_frame(0, -1, -1, -1, -1);
      check_frame(0, "post-reset");

      // Start pulses while busy and in the DONE cycle must be ignored.
      n = 3 * AW * AH;
      run_frame(0, -1, 5, 30, n + 5);
      check_frame(0, "restart-ignored");

      // Random frames on the non-square instance.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < BW*BH; i++) mem_b[i] = WIDTH'($urandom);
         repeat ($urandom_range(1, 4)) @(negedge clk);
         n = 3 * BW * BH;
         run_frame(1, -1, $urandom_range(1, n + 4), $urandom_range(1, n + 4),
                   (f == 1) ? n + 5 : -1);
         check_frame(1, $sformatf("random-%0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
